// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 frame scanner: FSM encoding, init command
// table, page/column addressing commands and the display window geometry.
package oled_pkg;

    typedef enum logic [2:0] {
        StResHold = 3'd0,
        StInit    = 3'd1,
        StIdle    = 3'd2,
        StPageCmd = 3'd3,
        StFetch   = 3'd4,
        StSend    = 3'd5,
        StDone    = 3'd6
    } oled_state_e;

    localparam int unsigned WinWidth = 128;
    localparam int unsigned NumPages = 8;
    localparam int unsigned InitLen  = 6;
    localparam int unsigned PageLen  = 3;

    localparam logic [7:0] PageCmdBase = 8'hB0;
    localparam logic [7:0] ColLoCmd    = 8'h00;
    localparam logic [7:0] ColHiCmd    = 8'h10;

    // Display off, page addressing mode, charge pump on, display on.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = 8'hAE;
            3'd1:    cmd = 8'h20;
            3'd2:    cmd = 8'h02;
            3'd3:    cmd = 8'h8D;
            3'd4:    cmd = 8'h14;
            default: cmd = 8'hAF;
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] page_cmd(input logic [1:0] idx, input logic [2:0] row);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = PageCmdBase | {5'b0, row};
            2'd1:    cmd = ColLoCmd;
            default: cmd = ColHiCmd;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/oled_spi_byte_tx.sv
// SPI mode-0 byte serializer for the SSD1306: cs framing with one half-period of lead and
// trail around the eight sclk pulses, MSB first, dc held for the whole byte.
module oled_spi_byte_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       dc_i,
    input  logic [7:0] byte_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       dc_o,
    output logic       cs_o,
    output logic       done_o
);

    localparam int unsigned   DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [4:0]    HalfLast = 5'd16;

    logic            active_q, active_d;
    logic [4:0]      hc_q, hc_d;
    logic [4:0]      hc_n;
    logic [DivW-1:0] div_q, div_d;
    logic [6:0]      shreg_q, shreg_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            dc_q, dc_d;
    logic            cs_q, cs_d;
    logic            done_q, done_d;

    assign hc_n = hc_q + 5'd1;

    // Half-period 0 is the cs lead, 1..15 odd are sclk high, 16 is the final low half.
    always_comb begin
        active_d = active_q;
        hc_d     = hc_q;
        div_d    = div_q;
        shreg_d  = shreg_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        dc_d     = dc_q;
        cs_d     = cs_q;
        done_d   = 1'b0;
        if (!active_q) begin
            if (start_i) begin
                active_d = 1'b1;
                hc_d     = 5'd0;
                div_d    = '0;
                cs_d     = 1'b0;
                dc_d     = dc_i;
                sclk_d   = 1'b0;
                mosi_d   = byte_i[7];
                shreg_d  = byte_i[6:0];
            end
        end else if (div_q == DivLast) begin
            div_d = '0;
            if (hc_q == HalfLast) begin
                active_d = 1'b0;
                cs_d     = 1'b1;
                done_d   = 1'b1;
            end else begin
                hc_d   = hc_n;
                sclk_d = hc_n[0];
                if (!hc_n[0] && hc_n != HalfLast) begin
                    mosi_d  = shreg_q[6];
                    shreg_d = {shreg_q[5:0], 1'b0};
                end
            end
        end else begin
            div_d = div_q + DivW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            hc_q     <= 5'd0;
            div_q    <= '0;
            shreg_q  <= 7'd0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            dc_q     <= 1'b0;
            cs_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            hc_q     <= hc_d;
            div_q    <= div_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            dc_q     <= dc_d;
            cs_q     <= cs_d;
            done_q   <= done_d;
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign dc_o   = dc_q;
    assign cs_o   = cs_q;
    assign done_o = done_q;

endmodule

// File: rtl/oled_frame_scan.sv
// SSD1306 frame scanner: walks a 128x8-page window of the display mux and streams it over SPI.
// Define OLED_INIT_SEQ_EN to include the power-up reset hold and controller init sequence.
module oled_frame_scan
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned RES_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] win_base,
    output logic [10:0] col_all,
    output logic [2:0]  row_all,
    input  logic [7:0]  data,
    output logic        oled_sclk,
    output logic        oled_mosi,
    output logic        oled_dc,
    output logic        oled_cs,
    output logic        oled_res,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [6:0] ColLast  = 7'(WinWidth - 1);
    localparam logic [2:0] RowLast  = 3'(NumPages - 1);
    localparam logic [2:0] PageLast = 3'(PageLen - 1);

`ifdef OLED_INIT_SEQ_EN
    localparam oled_state_e RstState = StResHold;
    localparam int unsigned RcW      = (RES_CYC > 1) ? $clog2(RES_CYC) : 1;
    localparam logic [RcW-1:0] RcLast = RcW'(RES_CYC - 1);
    localparam logic [2:0] InitLast  = 3'(InitLen - 1);

    logic           res_q, res_d;
    logic [RcW-1:0] rcnt_q, rcnt_d;
`else
    localparam oled_state_e RstState = StIdle;

    // Keeps RES_CYC referenced in builds without the power-up sequence.
    if (RES_CYC == 0) begin : g_res_cyc_unused
    end
`endif

    oled_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        wait_q, wait_d;
    logic [6:0]  col_q, col_d;
    logic [2:0]  row_q, row_d;
    logic [10:0] base_q, base_d;
    logic [7:0]  byte_q, byte_d;

    logic        tx_start;
    logic        tx_dc;
    logic [7:0]  tx_byte;
    logic        tx_done;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        col_d    = col_q;
        row_d    = row_q;
        base_d   = base_q;
        byte_d   = byte_q;
        tx_start = 1'b0;
        tx_dc    = 1'b0;
        tx_byte  = 8'h00;
`ifdef OLED_INIT_SEQ_EN
        res_d    = res_q;
        rcnt_d   = rcnt_q;
`endif
        case (state_q)
`ifdef OLED_INIT_SEQ_EN
            StResHold: begin
                if (rcnt_q == RcLast) begin
                    res_d   = 1'b1;
                    rcnt_d  = '0;
                    state_d = StInit;
                end else begin
                    rcnt_d = rcnt_q + RcW'(1);
                end
            end
            StInit: begin
                tx_byte = init_cmd(idx_q);
                if (!wait_q) begin
                    tx_start = 1'b1;
                    wait_d   = 1'b1;
                end else if (tx_done) begin
                    wait_d = 1'b0;
                    if (idx_q == InitLast) begin
                        idx_d   = 3'd0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`endif
            StIdle: begin
                if (en) begin
                    base_d  = win_base;
                    col_d   = 7'd0;
                    row_d   = 3'd0;
                    idx_d   = 3'd0;
                    state_d = StPageCmd;
                end
            end
            StPageCmd: begin
                tx_byte = page_cmd(idx_q[1:0], row_q);
                if (!wait_q) begin
                    tx_start = 1'b1;
                    wait_d   = 1'b1;
                end else if (tx_done) begin
                    wait_d = 1'b0;
                    if (idx_q == PageLast) begin
                        idx_d   = 3'd0;
                        state_d = StFetch;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            // Address is already stable; the second clock covers the ROM register stage.
            StFetch: begin
                if (idx_q == 3'd1) begin
                    byte_d  = data;
                    idx_d   = 3'd0;
                    state_d = StSend;
                end else begin
                    idx_d = 3'd1;
                end
            end
            StSend: begin
                tx_byte = byte_q;
                tx_dc   = 1'b1;
                if (!wait_q) begin
                    tx_start = 1'b1;
                    wait_d   = 1'b1;
                end else if (tx_done) begin
                    wait_d = 1'b0;
                    if (col_q == ColLast) begin
                        col_d = 7'd0;
                        if (row_q == RowLast) begin
                            state_d = StDone;
                        end else begin
                            row_d   = row_q + 3'd1;
                            state_d = StPageCmd;
                        end
                    end else begin
                        col_d   = col_q + 7'd1;
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RstState;
            idx_q   <= 3'd0;
            wait_q  <= 1'b0;
            col_q   <= 7'd0;
            row_q   <= 3'd0;
            base_q  <= 11'd0;
            byte_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            byte_q  <= byte_d;
        end
    end

`ifdef OLED_INIT_SEQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q  <= 1'b0;
            rcnt_q <= '0;
        end else begin
            res_q  <= res_d;
            rcnt_q <= rcnt_d;
        end
    end

    assign oled_res = res_q;
`else
    assign oled_res = 1'b1;
`endif

    oled_spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_byte_tx (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (tx_start),
        .dc_i    (tx_dc),
        .byte_i  (tx_byte),
        .sclk_o  (oled_sclk),
        .mosi_o  (oled_mosi),
        .dc_o    (oled_dc),
        .cs_o    (oled_cs),
        .done_o  (tx_done)
    );

    // Address wraps modulo 2048 through the natural 11-bit add.
    assign col_all    = base_q + {4'b0, col_q};
    assign row_all    = row_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

endmodule
